uart_tx_frame_ctrl: RTL and testbench

//  Frame sequencer for the UART transmitter. Accepts a DATA_VALID strobe and drives the parity calculator, the serializer and the output mux.

---
 rtl/uart_tx_frame_ctrl_pkg.sv | 44 ++++
 rtl/uart_tx_bit_cnt.sv | 51 +++++
 rtl/uart_tx_frame_ctrl.sv | 118 +++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl_pkg
//   Shared definitions for the UART transmit frame sequencer and its datapath
//   neighbours (serializer, parity calculator, line mux).
//   - tx_state_e : frame sequencer state encoding
//   - MUX_*      : line mux select codes, shared with the mux block
//   - helpers    : counter width and per-state mux decode
// -----------------------------------------------------------------------------
package uart_tx_frame_ctrl_pkg;

    // Binary state encoding; the three unused codes fall back to StIdle.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    // Line mux select codes.
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_DATA  = 2'b01;
    localparam logic [1:0] MUX_PAR   = 2'b10;
    localparam logic [1:0] MUX_STOP  = 2'b11;

    // Bit counter width; never zero so a one-bit frame still has a register.
    function automatic int unsigned cnt_width(input int unsigned data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

    // Line mux code presented in each state; idle and stop both hold the line high.
    function automatic logic [1:0] state_mux_sel(input tx_state_e state);
        logic [1:0] sel;
        sel = MUX_STOP;
        case (state)
            StStart:  sel = MUX_START;
            StData:   sel = MUX_DATA;
            StParity: sel = MUX_PAR;
            default:  sel = MUX_STOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_cnt
//   Data-bit counter for the UART frame sequencer. Counts enabled cycles and
//   wraps to zero after the terminal count (DataWidth-1).
// Ports
//   i_clk    in   transmit baud clock
//   i_rst_n  in   asynchronous active-low reset
//   i_en     in   count enable (one per data-bit cycle)
//   i_clr    in   synchronous clear, dominant over i_en
//   o_tc     out  terminal-count flag (counter at DataWidth-1)
// -----------------------------------------------------------------------------
module uart_tx_bit_cnt
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int unsigned CntW = cnt_width(DataWidth);
    localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    // ">=" rather than "==": an out-of-range value (non power-of-two width)
    // is treated as terminal and wraps, so the count never exceeds CntLast.
    assign o_tc = (r_cnt >= CntLast);

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en) begin
            w_cnt_d = o_tc ? '0 : r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//   Frame sequencer for the UART transmitter. On an accepted request it emits
//   start(0), DataWidth data bits LSB-first (via the serializer), an optional
//   parity bit, then stop(1). Outputs are Moore-decoded from state except
//   o_load, which is the accept strobe and follows i_data_valid combinationally.
// Ports
//   i_clk         in   transmit baud clock
//   i_rst_n       in   asynchronous active-low reset
//   i_data_valid  in   request to send; P_DATA stable while high
//   i_par_en      in   insert parity bit; sampled only on accept
//   o_load        out  accept strobe to serializer load / parity-calc read
//   o_ser_en      out  serializer shift enable, high in each data-bit cycle
//   o_mux_sel     out  line mux select (see MUX_* codes)
//   o_busy        out  frame in progress
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_data_valid,
    input  logic       i_par_en,
    output logic       o_load,
    output logic       o_ser_en,
    output logic [1:0] o_mux_sel,
    output logic       o_busy
);

    tx_state_e r_state;
    tx_state_e w_state_d;
    logic      r_par_en;
    logic      w_par_en_d;

    logic      w_accept;
    logic      w_cnt_en;
    logic      w_cnt_clr;
    logic      w_cnt_tc;

    uart_tx_bit_cnt #(
        .DataWidth (DataWidth)
    ) u_bit_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_cnt_en),
        .i_clr   (w_cnt_clr),
        .o_tc    (w_cnt_tc)
    );

    // Next-state and output decode.
    always_comb begin
        w_state_d  = r_state;
        w_accept   = 1'b0;
        w_cnt_en   = 1'b0;
        // Held clear outside DATA so every frame starts counting from zero.
        w_cnt_clr  = 1'b1;
        o_ser_en   = 1'b0;
        o_busy     = 1'b1;
        o_mux_sel  = state_mux_sel(r_state);

        case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_data_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_state_d = StData;
            end
            StData: begin
                o_ser_en  = 1'b1;
                w_cnt_en  = 1'b1;
                w_cnt_clr = 1'b0;
                if (w_cnt_tc) begin
                    w_state_d = r_par_en ? StParity : StStop;
                end
            end
            StParity: begin
                w_state_d = StStop;
            end
            StStop: begin
                // Back-to-back frames go straight from stop to start.
                if (i_data_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StStart;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                o_busy    = 1'b0;
                o_mux_sel = MUX_STOP;
                w_state_d = StIdle;
            end
        endcase

        // Parity selection is frozen for the whole frame at accept time.
        w_par_en_d = w_accept ? i_par_en : r_par_en;
    end

    // Gated by reset so no load strobe escapes while the block is held in reset.
    assign o_load = w_accept & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_par_en <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_par_en <= w_par_en_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
//   Self-checking bench for uart_tx_frame_ctrl. A queue-based frame model
//   predicts the line code for every cycle; a compare process checks all
//   outputs on each falling edge; directed scenarios add literal checks on
//   frame shape and event counts.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;

    localparam int unsigned DW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic       pe = 1'b0;
    logic       o_load;
    logic       o_ser_en;
    logic [1:0] o_mux_sel;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(
        .DataWidth (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_valid (dv),
        .i_par_en     (pe),
        .o_load       (o_load),
        .o_ser_en     (o_ser_en),
        .o_mux_sel    (o_mux_sel),
        .o_busy       (o_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: queue holds the line code for the current and future cycles
    // of the frame(s) in flight. Empty queue = idle. A request is taken when
    // idle or in the last (stop) cycle of a frame.
    logic [1:0] exp_q[$];
    bit         m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            m_take = dv && (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_take) begin
                exp_q.push_back(2'b00);
                for (int i = 0; i < DW; i++) exp_q.push_back(2'b01);
                if (pe) exp_q.push_back(2'b10);
                exp_q.push_back(2'b11);
            end
        end
    end

    // Compare process.
    bit         c_busy;
    logic [1:0] c_mux;
    always @(negedge clk) begin
        c_busy = exp_q.size() > 0;
        c_mux  = c_busy ? exp_q[0] : 2'b11;
        check("busy", 32'(o_busy), 32'(c_busy));
        check("mux_sel", 32'(o_mux_sel), 32'(c_mux));
        check("ser_en", 32'(o_ser_en), 32'(c_busy && c_mux == 2'b01));
        check("load", 32'(o_load), 32'(rst_n && dv && exp_q.size() <= 1));
    end

    // Event monitor (only writer of these counters).
    int  mon_busy = 0, mon_load = 0, mon_ser = 0, mon_par = 0, mon_fall = 0;
    logic mon_prev_busy = 1'b0;
    always @(negedge clk) begin
        if (o_busy) mon_busy++;
        if (o_load) mon_load++;
        if (o_ser_en) mon_ser++;
        if (o_busy && o_mux_sel == 2'b10) mon_par++;
        if (mon_prev_busy && !o_busy) mon_fall++;
        mon_prev_busy = o_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s_busy, s_load, s_ser, s_par, s_fall;
    task automatic snap();
        s_busy = mon_busy;
        s_load = mon_load;
        s_ser  = mon_ser;
        s_par  = mon_par;
        s_fall = mon_fall;
    endtask

    task automatic check_window(input string tag, input int busy, input int load,
                                input int ser, input int par, input int fall);
        check({tag, "_busy_cycles"}, 32'(mon_busy - s_busy), 32'(busy));
        check({tag, "_load_pulses"}, 32'(mon_load - s_load), 32'(load));
        check({tag, "_ser_en_cycles"}, 32'(mon_ser - s_ser), 32'(ser));
        check({tag, "_parity_cycles"}, 32'(mon_par - s_par), 32'(par));
        check({tag, "_busy_falls"}, 32'(mon_fall - s_fall), 32'(fall));
    endtask

    // Called in the START cycle; walks the frame cycle by cycle.
    task automatic check_frame_seq(input string tag, input bit par);
        logic [1:0] lit;
        int len;
        len = par ? 11 : 10;
        for (int c = 0; c < len; c++) begin
            if (c == 0) lit = 2'b00;
            else if (c <= DW) lit = 2'b01;
            else if (par && c == DW + 1) lit = 2'b10;
            else lit = 2'b11;
            check({tag, "_seq_mux"}, 32'(o_mux_sel), 32'(lit));
            check({tag, "_seq_busy"}, 32'(o_busy), 32'd1);
            tick(1);
        end
    endtask

    initial begin
        // 1: reset with random inputs
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dv = 1'($urandom_range(0, 1));
            pe = 1'($urandom_range(0, 1));
            #1;
            check("rst_mux", 32'(o_mux_sel), 32'h3);
            check("rst_busy", 32'(o_busy), 32'h0);
            check("rst_load", 32'(o_load), 32'h0);
            check("rst_ser_en", 32'(o_ser_en), 32'h0);
        end
        dv = 1'b0;
        pe = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_idle_busy", 32'(o_busy), 32'h0);
        check("post_rst_idle_mux", 32'(o_mux_sel), 32'h3);

        // 2: parity frame, single-cycle request
        snap();
        dv = 1'b1;
        pe = 1'b1;
        tick(1);
        dv = 1'b0;
        check_frame_seq("par", 1'b1);
        tick(2);
        check("par_idle_after", 32'(o_busy), 32'h0);
        check_window("par", 11, 1, 8, 1, 1);

        // 3: no-parity frame, PAR_EN toggled mid-frame
        snap();
        dv = 1'b1;
        pe = 1'b0;
        tick(1);
        dv = 1'b0;
        tick(3);
        pe = 1'b1;
        tick(2);
        pe = 1'b0;
        tick(2);
        pe = 1'b1;
        tick(10);
        pe = 1'b0;
        check_window("nopar", 10, 1, 8, 0, 1);

        // 4: back-to-back frames with request held
        snap();
        dv = 1'b1;
        pe = 1'b1;
        tick(1);
        tick(11);
        check("b2b_second_start", 32'(o_mux_sel), 32'h0);
        dv = 1'b0;
        tick(15);
        check_window("b2b", 22, 2, 16, 2, 1);

        // 5: request during DATA ignored
        snap();
        dv = 1'b1;
        pe = 1'b0;
        tick(1);
        dv = 1'b0;
        tick(3);
        check("ign_in_data", 32'(o_mux_sel), 32'h1);
        dv = 1'b1;
        #1;
        check("ign_no_load", 32'(o_load), 32'h0);
        tick(1);
        dv = 1'b0;
        tick(12);
        check("ign_idle_after", 32'(o_busy), 32'h0);
        check_window("ign", 10, 1, 8, 0, 1);

        // 6: reset during 4th data bit, then a clean frame
        dv = 1'b1;
        pe = 1'b1;
        tick(1);
        dv = 1'b0;
        tick(4);
        check("mid_rst_in_data", 32'(o_mux_sel), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mux", 32'(o_mux_sel), 32'h3);
        check("mid_rst_busy", 32'(o_busy), 32'h0);
        check("mid_rst_ser_en", 32'(o_ser_en), 32'h0);
        check("mid_rst_load", 32'(o_load), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        snap();
        dv = 1'b1;
        tick(1);
        dv = 1'b0;
        check_frame_seq("after_rst", 1'b1);
        tick(2);
        check_window("after_rst", 11, 1, 8, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
